// File: rtl/perf_window_sampler_pkg.sv
// perf_pkg: shared types and helpers for the performance window sampler.
//   SEQ_W       width of the window sequence number carried in every snapshot
//   perf_snap_t snapshot layout for the default 32-bit accumulator build
//   sat_add     saturating add at a caller-chosen width (<= SAT_MAX_W),
//               returns {carry, result}; carry means the true sum exceeded
//               the all-ones limit and the result was clamped.
package perf_pkg;

  localparam int SEQ_W     = 8;
  localparam int ACC_W_DEF = 32;
  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic [ACC_W_DEF-1:0] total;
    logic                 sat;
    logic [SEQ_W-1:0]     seq;
  } perf_snap_t;

  // Operands are zero-extended by the caller; w selects the saturation limit.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int                   w
  );
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
    if (sum > lim) begin
      sat_add = {1'b1, lim[SAT_MAX_W-1:0]};
    end else begin
      sat_add = {1'b0, sum[SAT_MAX_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/perf_snap_fifo.sv
// perf_snap_fifo: synchronous show-ahead FIFO for window snapshots.
//   clk, reset  clock, synchronous active-high reset (empties the FIFO)
//   i_push      write i_data; accepted when not full, or when full and a pop
//               happens in the same cycle
//   i_pop       remove head entry (ignored when empty)
//   o_data      head entry, valid whenever !o_empty; zero when empty
//   o_full      DEPTH entries held
//   o_empty     no entries held
//   o_level     registered exact occupancy
module perf_snap_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_level   = r_level;
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a push if the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/perf_window_sampler.sv
// perf_window_sampler: follows a small wrapping upstream event counter,
// accumulates its per-cycle deltas into a wide per-window total and emits a
// snapshot every window_len enabled cycles through a show-ahead FIFO.
//   clk, reset       clock, synchronous active-high reset
//   i_cnt_in         upstream counter value (wraps at 2^CNT_W)
//   i_sample_en      windowing enable; dropping it discards the partial window
//   i_window_len     enabled cycles per window, 0 disables windowing
//   i_clr_stats      pulse: clear o_ovf_sticky and o_drop_cnt
//   o_snap_valid     snapshot available (FIFO non-empty)
//   i_snap_ready     consumer accepts the head snapshot
//   o_snap_total     head snapshot: events seen in the window (saturating)
//   o_snap_sat       head snapshot: accumulator saturated in the window
//   o_snap_seq       head snapshot: window sequence number, wraps 255->0
//   o_fifo_level     FIFO occupancy
//   o_ovf_sticky     a snapshot has been dropped since the last clear
//   o_drop_cnt       dropped snapshots, saturating
//
// Snapshot handshake: a snapshot transfers on every rising edge where
// o_snap_valid && i_snap_ready. While o_snap_valid is high and i_snap_ready
// is low, all o_snap_* outputs hold stable. o_snap_valid never depends
// combinationally on i_snap_ready.
module perf_window_sampler #(
  parameter int CNT_W      = 4,
  parameter int ACC_W      = 32,
  parameter int WIN_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CNT_W-1:0]              i_cnt_in,
  input  logic                          i_sample_en,
  input  logic [WIN_W-1:0]              i_window_len,
  input  logic                          i_clr_stats,
  output logic                          o_snap_valid,
  input  logic                          i_snap_ready,
  output logic [ACC_W-1:0]              o_snap_total,
  output logic                          o_snap_sat,
  output logic [7:0]                    o_snap_seq,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_ovf_sticky,
  output logic [DROP_W-1:0]             o_drop_cnt
);

  import perf_pkg::*;

  typedef struct packed {
    logic [ACC_W-1:0] total;
    logic             sat;
    logic [SEQ_W-1:0] seq;
  } snap_t;

  localparam int SNAP_W = $bits(snap_t);

  logic [CNT_W-1:0]  r_cnt_prev;
  logic [ACC_W-1:0]  r_acc;
  logic              r_sat;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [SEQ_W-1:0]  r_seq;
  logic              r_ovf_sticky;
  logic [DROP_W-1:0] r_drop_cnt;

  logic [CNT_W-1:0]     w_delta;
  logic                 w_active;
  logic                 w_close;
  logic [SAT_MAX_W:0]   w_add;
  logic [ACC_W-1:0]     w_sum;
  logic                 w_carry;
  logic [SAT_MAX_W-ACC_W-1:0] w_unused_hi;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  snap_t                w_push_snap;
  snap_t                w_head;

  // Modular difference: a 15->0 wrap reads as one event, never as -15.
  assign w_delta  = i_cnt_in - r_cnt_prev;
  assign w_active = i_sample_en && (i_window_len != '0);
  // ">=" rather than "==" so shrinking window_len below the current count
  // closes on the next active cycle instead of running to counter wrap.
  assign w_close  = w_active && (r_win_cnt >= (i_window_len - WIN_W'(1)));

  assign w_add       = sat_add(SAT_MAX_W'(r_acc), SAT_MAX_W'(w_delta), ACC_W);
  assign w_sum       = w_add[ACC_W-1:0];
  assign w_unused_hi = w_add[SAT_MAX_W-1:ACC_W];
  assign w_carry     = w_add[SAT_MAX_W];

  assign w_push_snap.total = w_sum;
  assign w_push_snap.sat   = r_sat | w_carry;
  assign w_push_snap.seq   = r_seq;

  assign w_pop  = o_snap_valid && i_snap_ready;
  // Only a push into a full FIFO with no simultaneous pop loses data.
  assign w_drop = w_close && w_full && !w_pop;

  perf_snap_fifo #(
    .WIDTH (SNAP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_close),
    .i_data  (w_push_snap),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  assign o_snap_valid = !w_empty;
  assign o_snap_total = w_head.total;
  assign o_snap_sat   = w_head.sat;
  assign o_snap_seq   = w_head.seq;
  assign o_ovf_sticky = r_ovf_sticky;
  assign o_drop_cnt   = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_prev <= '0;
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_win_cnt  <= '0;
      r_seq      <= '0;
    end else begin
      // Tracked unconditionally so enabling never sees a stale delta.
      r_cnt_prev <= i_cnt_in;
      if (!w_active) begin
        r_acc     <= '0;
        r_sat     <= 1'b0;
        r_win_cnt <= '0;
      end else if (w_close) begin
        r_acc     <= '0;
        r_sat     <= 1'b0;
        r_win_cnt <= '0;
        // Advances even when the snapshot is dropped, leaving a visible gap.
        r_seq     <= r_seq + SEQ_W'(1);
      end else begin
        r_acc     <= w_sum;
        r_sat     <= r_sat | w_carry;
        r_win_cnt <= r_win_cnt + WIN_W'(1);
      end
    end
  end

  // A drop in the same cycle as a clear wins: the new drop is the first count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_sticky <= 1'b0;
      r_drop_cnt   <= '0;
    end else if (w_drop) begin
      r_ovf_sticky <= 1'b1;
      if (i_clr_stats) begin
        r_drop_cnt <= DROP_W'(1);
      end else if (r_drop_cnt != '1) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end else if (i_clr_stats) begin
      r_ovf_sticky <= 1'b0;
      r_drop_cnt   <= '0;
    end
  end

endmodule
